// File: rtl/uart_cmd_rx.sv
// ---------------------------------------------------------------------------
// uart_cmd_rx : 8N1 UART receiver with a small receive buffer.
//
// Optional feature macro: UART_CMD_RX_FIFO_EN
//   defined   -> 4-entry FIFO, uart_dat_o shows the oldest entry.
//   undefined -> single holding register.
//
// Parameters
//   CLK_DIV      system clock cycles per bit (8..1023)
//
// Ports
//   sys_clk_i    system clock, rising edge
//   sys_rst_n_i  asynchronous active-low reset
//   uart_rx      serial line, asynchronous, idle high
//   uart_rd_i    pop / acknowledge the byte on uart_dat_o
//   uart_dat_o   byte at head of buffer
//   uart_rdy_o   uart_dat_o holds an unread byte
//   uart_ferr_o  one-cycle framing error pulse
//   uart_ovf_o   sticky overrun flag (cleared by reset only)
//   uart_busy_o  receiver FSM not idle
// ---------------------------------------------------------------------------
module uart_cmd_rx #(
  parameter int CLK_DIV = 83
) (
  input  logic       sys_clk_i,
  input  logic       sys_rst_n_i,
  input  logic       uart_rx,
  input  logic       uart_rd_i,
  output logic [7:0] uart_dat_o,
  output logic       uart_rdy_o,
  output logic       uart_ferr_o,
  output logic       uart_ovf_o,
  output logic       uart_busy_o
);

  // Half-bit load centres the start-bit check; full-bit load steps bit centres.
  localparam logic [9:0] HALF_LD = 10'(CLK_DIV / 2 - 1);
  localparam logic [9:0] FULL_LD = 10'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  state_t      state_r, state_nxt_s;
  logic [9:0]  cnt_r, cnt_nxt_s;
  logic [2:0]  bit_idx_r, bit_idx_nxt_s;
  logic [7:0]  shift_r, shift_nxt_s;
  logic        rx_meta_r, rx_sync_r;
  logic        accept_s, ferr_s;
  logic        ferr_r, busy_r, ovf_r, rdy_r;
  logic [7:0]  dat_r;
  logic        rdy_nxt_s;
  logic [7:0]  dat_nxt_s;
  logic        pop_s, push_s, full_s, ovf_set_s;

  // Two-flop synchronizer; resets to the idle-high line level.
  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
    end else begin
      rx_meta_r <= uart_rx;
      rx_sync_r <= rx_meta_r;
    end
  end

  // FSM state, bit timing counter, bit index, shift register and status flops.
  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      state_r   <= IDLE;
      cnt_r     <= 10'd0;
      bit_idx_r <= 3'd0;
      shift_r   <= 8'h00;
      ferr_r    <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      bit_idx_r <= bit_idx_nxt_s;
      shift_r   <= shift_nxt_s;
      ferr_r    <= ferr_s;
      busy_r    <= (state_nxt_s != IDLE);
    end
  end

  // Next-state logic: every state acts only when the bit counter reaches zero.
  always_comb begin
    state_nxt_s   = state_r;
    cnt_nxt_s     = cnt_r;
    bit_idx_nxt_s = bit_idx_r;
    shift_nxt_s   = shift_r;
    accept_s      = 1'b0;
    ferr_s        = 1'b0;
    case (state_r)
      IDLE: begin
        if (!rx_sync_r) begin
          state_nxt_s = START;
          cnt_nxt_s   = HALF_LD;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      START: begin
        if (cnt_r != 10'd0) begin
          cnt_nxt_s = cnt_r - 10'd1;
        end else if (rx_sync_r) begin
          state_nxt_s = IDLE;               // glitch: silently abandon
        end else begin
          state_nxt_s   = DATA;
          cnt_nxt_s     = FULL_LD;
          bit_idx_nxt_s = 3'd0;
        end
      end
      DATA: begin
        if (cnt_r != 10'd0) begin
          cnt_nxt_s = cnt_r - 10'd1;
        end else begin
          shift_nxt_s = {rx_sync_r, shift_r[7:1]};   // LSB arrives first
          cnt_nxt_s   = FULL_LD;
          if (bit_idx_r == 3'd7) begin
            state_nxt_s = STOP;
          end else begin
            bit_idx_nxt_s = bit_idx_r + 3'd1;
          end
        end
      end
      STOP: begin
        if (cnt_r != 10'd0) begin
          cnt_nxt_s = cnt_r - 10'd1;
        end else if (rx_sync_r) begin
          accept_s    = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          ferr_s      = 1'b1;
          state_nxt_s = WAIT_HIGH;          // hold off until the break ends
        end
      end
      WAIT_HIGH: begin
        if (rx_sync_r) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = WAIT_HIGH;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

`ifdef UART_CMD_RX_FIFO_EN
  logic [3:0][7:0] mem_r, mem_nxt_s;
  logic [1:0]      wr_ptr_r, wr_ptr_nxt_s, rd_ptr_r, rd_ptr_nxt_s;
  logic [2:0]      fifo_cnt_r, fifo_cnt_nxt_s;

  // FIFO storage and pointers.
  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      mem_r      <= '{default: 8'h00};
      wr_ptr_r   <= 2'd0;
      rd_ptr_r   <= 2'd0;
      fifo_cnt_r <= 3'd0;
    end else begin
      mem_r      <= mem_nxt_s;
      wr_ptr_r   <= wr_ptr_nxt_s;
      rd_ptr_r   <= rd_ptr_nxt_s;
      fifo_cnt_r <= fifo_cnt_nxt_s;
    end
  end

  // FIFO update; a pop frees a slot for a push in the same cycle.
  always_comb begin
    pop_s     = uart_rd_i && (fifo_cnt_r != 3'd0);
    full_s    = (fifo_cnt_r == 3'd4);
    push_s    = accept_s && (!full_s || pop_s);
    ovf_set_s = accept_s && full_s && !pop_s;
    mem_nxt_s = mem_r;
    if (push_s) begin
      mem_nxt_s[wr_ptr_r] = shift_r;
      wr_ptr_nxt_s        = wr_ptr_r + 2'd1;
    end else begin
      wr_ptr_nxt_s = wr_ptr_r;
    end
    if (pop_s) begin
      rd_ptr_nxt_s = rd_ptr_r + 2'd1;
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end
    case ({push_s, pop_s})
      2'b10:   fifo_cnt_nxt_s = fifo_cnt_r + 3'd1;
      2'b01:   fifo_cnt_nxt_s = fifo_cnt_r - 3'd1;
      default: fifo_cnt_nxt_s = fifo_cnt_r;
    endcase
    // Registered head so the output reflects this cycle's push/pop.
    dat_nxt_s = mem_nxt_s[rd_ptr_nxt_s];
    rdy_nxt_s = (fifo_cnt_nxt_s != 3'd0);
  end
`else
  // Single holding register; uart_rd_i acknowledges it.
  always_comb begin
    pop_s     = uart_rd_i && rdy_r;
    full_s    = rdy_r;
    push_s    = accept_s && (!full_s || pop_s);
    ovf_set_s = accept_s && full_s && !pop_s;
    if (push_s) begin
      dat_nxt_s = shift_r;
      rdy_nxt_s = 1'b1;
    end else if (pop_s) begin
      dat_nxt_s = dat_r;
      rdy_nxt_s = 1'b0;
    end else begin
      dat_nxt_s = dat_r;
      rdy_nxt_s = rdy_r;
    end
  end
`endif

  // Output head register, ready flag and sticky overrun.
  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      dat_r <= 8'h00;
      rdy_r <= 1'b0;
      ovf_r <= 1'b0;
    end else begin
      dat_r <= dat_nxt_s;
      rdy_r <= rdy_nxt_s;
      ovf_r <= ovf_r | ovf_set_s;
    end
  end

  assign uart_dat_o  = dat_r;
  assign uart_rdy_o  = rdy_r;
  assign uart_ferr_o = ferr_r;
  assign uart_ovf_o  = ovf_r;
  assign uart_busy_o = busy_r;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// ---------------------------------------------------------------------------
// Self-checking bench for uart_cmd_rx: vector table, hand-written corner
// sequences and randomized frames against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_uart_cmd_rx;

  localparam int CLK_DIV = 83;
`ifdef UART_CMD_RX_FIFO_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 1;
`endif
  // Clock edge (counted from the first edge that sees the start bit) that
  // samples the stop bit: 2 sync stages, half-bit wait, then 9 full bits.
  localparam int STOP_EDGE = 2 + CLK_DIV / 2 + 9 * CLK_DIV;

  logic       sys_clk_i = 1'b0;
  logic       sys_rst_n_i;
  logic       uart_rx;
  logic       uart_rd_i;
  logic [7:0] uart_dat_o;
  logic       uart_rdy_o;
  logic       uart_ferr_o;
  logic       uart_ovf_o;
  logic       uart_busy_o;

  int n_checks = 0;
  int n_fail   = 0;
  int ferr_seen = 0;

  uart_cmd_rx #(.CLK_DIV(CLK_DIV)) dut (
    .sys_clk_i   (sys_clk_i),
    .sys_rst_n_i (sys_rst_n_i),
    .uart_rx     (uart_rx),
    .uart_rd_i   (uart_rd_i),
    .uart_dat_o  (uart_dat_o),
    .uart_rdy_o  (uart_rdy_o),
    .uart_ferr_o (uart_ferr_o),
    .uart_ovf_o  (uart_ovf_o),
    .uart_busy_o (uart_busy_o)
  );

  always #5 sys_clk_i = ~sys_clk_i;

  // Count framing-error pulse cycles.
  always @(negedge sys_clk_i) begin
    if (uart_ferr_o === 1'b1) ferr_seen <= ferr_seen + 1;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge sys_clk_i);
    sys_rst_n_i = 1'b0;
    uart_rx     = 1'b1;
    uart_rd_i   = 1'b0;
    repeat (3) @(negedge sys_clk_i);
    sys_rst_n_i = 1'b1;
    repeat (4) @(negedge sys_clk_i);
  endtask

  // Drive one frame bit-by-bit on negedges; optionally hold the line low
  // after the frame, pulse uart_rd_i at one clock, and report the sample
  // index at which uart_rdy_o rose.
  task automatic run_frame(input logic [7:0] d, input bit stop_ok, input int rd_at,
                           input int extra_low, input int tail, output int rise_idx);
    logic [9:0] fr;
    logic       prev_rdy;
    int         total;
    fr       = {stop_ok, d, 1'b0};
    total    = 10 * CLK_DIV + extra_low + tail;
    rise_idx = -1;
    prev_rdy = uart_rdy_o;
    for (int i = 0; i < total; i++) begin
      @(negedge sys_clk_i);
      if (rise_idx < 0 && !prev_rdy && uart_rdy_o) rise_idx = i;
      if (i < 10 * CLK_DIV) uart_rx = fr[i / CLK_DIV];
      else if (i < 10 * CLK_DIV + extra_low) uart_rx = 1'b0;
      else uart_rx = 1'b1;
      uart_rd_i = (i == rd_at);
    end
    uart_rd_i = 1'b0;
  endtask

  task automatic pulse_rd();
    @(negedge sys_clk_i);
    uart_rd_i = 1'b1;
    @(negedge sys_clk_i);
    uart_rd_i = 1'b0;
  endtask

  task automatic read_pop(input string nm, input logic [7:0] exp);
    @(negedge sys_clk_i);
    check({nm, "_rdy"}, {31'd0, uart_rdy_o}, 32'd1);
    check({nm, "_dat"}, {24'd0, uart_dat_o}, {24'd0, exp});
    uart_rd_i = 1'b1;
    @(negedge sys_clk_i);
    uart_rd_i = 1'b0;
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, "_dat"},  {24'd0, uart_dat_o}, 32'h00);
    check({nm, "_rdy"},  {31'd0, uart_rdy_o}, 32'd0);
    check({nm, "_ferr"}, {31'd0, uart_ferr_o}, 32'd0);
    check({nm, "_ovf"},  {31'd0, uart_ovf_o}, 32'd0);
    check({nm, "_busy"}, {31'd0, uart_busy_o}, 32'd0);
  endtask

  typedef struct {
    logic [7:0] data;
    bit         stop_ok;
    bit         exp_rdy;
    logic [7:0] exp_dat;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int         rise, f0;
    logic [7:0] d, e;
    bit         ok;
    bit         movf;
    logic [7:0] mq[$];

    vecs[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 0};
    vecs[1] = '{8'h3C, 1'b0, 1'b0, 8'h00, 1};
    vecs[2] = '{8'h00, 1'b1, 1'b1, 8'h00, 0};
    vecs[3] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 0};
    vecs[4] = '{8'h55, 1'b1, 1'b1, 8'h55, 0};
    vecs[5] = '{8'h81, 1'b0, 1'b0, 8'h00, 1};
    vecs[6] = '{8'h7E, 1'b1, 1'b1, 8'h7E, 0};

    sys_rst_n_i = 1'b0;
    uart_rx     = 1'b1;
    uart_rd_i   = 1'b0;
    repeat (3) @(negedge sys_clk_i);
    check_reset_outputs("reset");
    sys_rst_n_i = 1'b1;
    repeat (4) @(negedge sys_clk_i);

    // A5 with rd low: ready exactly one cycle after the stop-bit sample.
    f0 = ferr_seen;
    run_frame(8'hA5, 1'b1, -1, 0, 20, rise);
    check("a5_latency", rise, STOP_EDGE + 1);
    check("a5_dat", {24'd0, uart_dat_o}, 32'hA5);
    check("a5_ferr", ferr_seen - f0, 0);
    check("a5_ovf", {31'd0, uart_ovf_o}, 32'd0);
    pulse_rd();

    // Vector table, one frame per entry, buffer drained after each.
    foreach (vecs[i]) begin
      f0 = ferr_seen;
      run_frame(vecs[i].data, vecs[i].stop_ok, -1, 0, 20, rise);
      check($sformatf("vec%0d_rdy", i), {31'd0, uart_rdy_o}, {31'd0, vecs[i].exp_rdy});
      if (vecs[i].exp_rdy) check($sformatf("vec%0d_dat", i), {24'd0, uart_dat_o}, {24'd0, vecs[i].exp_dat});
      check($sformatf("vec%0d_ferr", i), ferr_seen - f0, vecs[i].exp_ferr);
      check($sformatf("vec%0d_ovf", i), {31'd0, uart_ovf_o}, 32'd0);
      check($sformatf("vec%0d_busy", i), {31'd0, uart_busy_o}, 32'd0);
      if (vecs[i].exp_rdy) pulse_rd();
    end

    // 20-cycle low glitch on an idle line.
    f0 = ferr_seen;
    for (int i = 0; i < 200; i++) begin
      @(negedge sys_clk_i);
      uart_rx = (i >= 20);
    end
    check("glitch_rdy", {31'd0, uart_rdy_o}, 32'd0);
    check("glitch_ferr", ferr_seen - f0, 0);
    check("glitch_busy", {31'd0, uart_busy_o}, 32'd0);

    // Break: 3C with low stop bit, line held low 2000 more cycles.
    f0 = ferr_seen;
    run_frame(8'h3C, 1'b0, -1, 2000, 0, rise);
    check("break_ferr", ferr_seen - f0, 1);
    check("break_busy_low", {31'd0, uart_busy_o}, 32'd1);
    check("break_rdy", {31'd0, uart_rdy_o}, 32'd0);
    uart_rx = 1'b1;
    repeat (10) @(negedge sys_clk_i);
    check("break_busy_high", {31'd0, uart_busy_o}, 32'd0);
    check("break_ferr_once", ferr_seen - f0, 1);

    // Overrun: fill the buffer plus one more, no reads.
    do_reset();
    for (int k = 1; k <= CAP + 1; k++) run_frame(8'(k), 1'b1, -1, 0, 10, rise);
    check("ovf_flag", {31'd0, uart_ovf_o}, 32'd1);
    for (int k = 1; k <= CAP; k++) read_pop($sformatf("ovf_rd%0d", k), 8'(k));
    @(negedge sys_clk_i);
    check("ovf_empty", {31'd0, uart_rdy_o}, 32'd0);
    check("ovf_sticky", {31'd0, uart_ovf_o}, 32'd1);

    // Full buffer, read pulsed on the accepting clock: no overrun.
    do_reset();
    for (int k = 0; k < CAP; k++) run_frame(8'(8'h10 + k), 1'b1, -1, 0, 10, rise);
    run_frame(8'h77, 1'b1, STOP_EDGE, 0, 10, rise);
    check("rdacc_ovf", {31'd0, uart_ovf_o}, 32'd0);
    for (int k = 1; k < CAP; k++) read_pop($sformatf("rdacc_rd%0d", k), 8'(8'h10 + k));
    read_pop("rdacc_new", 8'h77);
    @(negedge sys_clk_i);
    check("rdacc_empty", {31'd0, uart_rdy_o}, 32'd0);

    // Reset in the middle of FF's data bits, then a clean 42.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      @(negedge sys_clk_i);
      uart_rx = (i >= CLK_DIV);
    end
    check("midrst_busy_before", {31'd0, uart_busy_o}, 32'd1);
    sys_rst_n_i = 1'b0;
    uart_rx     = 1'b1;
    repeat (3) @(negedge sys_clk_i);
    check_reset_outputs("midrst");
    sys_rst_n_i = 1'b1;
    repeat (CLK_DIV * 2) @(negedge sys_clk_i);
    check("midrst_idle_rdy", {31'd0, uart_rdy_o}, 32'd0);
    pulse_rd();                                   // ignored: buffer empty
    f0 = ferr_seen;
    run_frame(8'h42, 1'b1, -1, 0, 20, rise);
    check("midrst_ferr", ferr_seen - f0, 0);
    check("midrst_ovf", {31'd0, uart_ovf_o}, 32'd0);
    read_pop("midrst_42", 8'h42);
    @(negedge sys_clk_i);
    check("midrst_only_one", {31'd0, uart_rdy_o}, 32'd0);

    // Randomized frames against a queue model of the buffer.
    do_reset();
    movf = 1'b0;
    mq.delete();
    for (int f = 0; f < 25; f++) begin
      int nrd;
      nrd = $urandom_range(0, 2);
      for (int r = 0; r < nrd; r++) begin
        if (mq.size() > 0) begin
          e = mq.pop_front();
          read_pop($sformatf("rnd%0d_rd", f), e);
        end
      end
      d  = 8'($urandom);
      ok = ($urandom_range(0, 5) != 0);
      f0 = ferr_seen;
      run_frame(d, ok, -1, 0, 20, rise);
      if (ok) begin
        if (mq.size() < CAP) mq.push_back(d);
        else movf = 1'b1;
      end
      check($sformatf("rnd%0d_ferr", f), ferr_seen - f0, ok ? 0 : 1);
      check($sformatf("rnd%0d_rdy", f), {31'd0, uart_rdy_o}, (mq.size() > 0) ? 32'd1 : 32'd0);
      check($sformatf("rnd%0d_ovf", f), {31'd0, uart_ovf_o}, {31'd0, movf});
      if (mq.size() > 0) check($sformatf("rnd%0d_dat", f), {24'd0, uart_dat_o}, {24'd0, mq[0]});
    end
    while (mq.size() > 0) begin
      e = mq.pop_front();
      read_pop("rnd_drain", e);
    end
    @(negedge sys_clk_i);
    check("rnd_drained", {31'd0, uart_rdy_o}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_cmd_rx.md
UART_CMD_RX -- requirements
Module: uart_cmd_rx

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 83, meaning clock cycles per bit (9.6 MHz / 115200 baud); legal range 8..1023.
REQ-002 The block SHALL have port sys_clk_i  input  1  system clock, all logic on its rising edge.
REQ-003 The block SHALL have port sys_rst_n_i  input  1  reset; reset is asynchronous and active-low.
REQ-004 The block SHALL have port uart_rx  input  1  serial line from host, asynchronous to sys_clk_i, idle high.
REQ-005 The block SHALL have port uart_rd_i  input  1  consumer pops/acknowledges the byte at uart_dat_o.
REQ-006 The block SHALL have port uart_dat_o  output  8  received byte at head of buffer.
REQ-007 The block SHALL have port uart_rdy_o  output  1  uart_dat_o holds a valid unread byte.
REQ-008 The block SHALL have port uart_ferr_o  output  1  one-cycle pulse on framing error.
REQ-009 The block SHALL have port uart_ovf_o  output  1  sticky overrun flag, cleared only by reset.
REQ-010 The block SHALL have port uart_busy_o  output  1  high whenever the FSM is not in IDLE.

Function
REQ-011 uart_rx SHALL pass through a 2-flop synchronizer before use; all references to "rx" below mean the synchronized value.
REQ-012 FSM states SHALL be IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-013 IDLE: rx low -> START, bit counter loaded with CLK_DIV/2 - 1 (integer division).
REQ-014 START: at counter 0, rx high -> IDLE (glitch, no flags); rx low -> DATA, counter loaded with CLK_DIV - 1, bit index 0.
REQ-015 DATA: at each counter 0, sample rx into shift bit (LSB first), reload CLK_DIV - 1; after bit index 7 -> STOP.
REQ-016 STOP: at counter 0, rx high -> byte accepted, -> IDLE; rx low -> uart_ferr_o pulse, byte discarded, -> WAIT_HIGH.
REQ-017 WAIT_HIGH: remain until rx high, then -> IDLE (break conditions produce exactly one ferr pulse).
REQ-018 An accepted byte SHALL be visible on uart_dat_o with uart_rdy_o high on the cycle after the stop-bit sample (1-cycle latency), if buffer space exists.
REQ-019 uart_rd_i while uart_rdy_o low SHALL be ignored.
REQ-020 Accepted byte with no buffer space and no same-cycle uart_rd_i SHALL be dropped and set uart_ovf_o; buffer contents unchanged.
REQ-021 Accepted byte with buffer full and same-cycle uart_rd_i SHALL be stored (pop and push both take effect, no overrun).
REQ-022 Counters SHALL be sized for CLK_DIV up to 1023 and never wrap in normal operation.

Reset
REQ-023 On sys_rst_n_i low: FSM IDLE, counters 0, buffer empty, uart_dat_o 8'h00, uart_rdy_o 0, uart_ferr_o 0, uart_ovf_o 0, uart_busy_o 0; synchronizer flops set to 1.
REQ-024 Reset asserted mid-frame SHALL abort the frame; after release the block SHALL wait for a fresh falling edge (a line still low at release is treated as a start bit and validated per REQ-014).

Configuration
REQ-025 Macro UART_CMD_RX_FIFO_EN defined: buffer SHALL be a 4-entry FIFO; uart_dat_o shows oldest entry; uart_rd_i pops; uart_rdy_o = not empty.
REQ-026 UART_CMD_RX_FIFO_EN undefined: buffer SHALL be a single holding register; uart_rd_i clears uart_rdy_o; full = uart_rdy_o high.

Verification
REQ-027 Send 8'hA5 at CLK_DIV=83, rd held low -> uart_dat_o=8'hA5, uart_rdy_o=1 one cycle after stop sample, ferr/ovf 0.
REQ-028 Low glitch of 20 cycles on idle line -> returns to IDLE, no rdy, no ferr.
REQ-029 Send 8'h3C with stop bit low, line held low 2000 cycles -> exactly one ferr pulse, no byte stored, busy high until line returns high.
REQ-030 FIFO_EN: send 8'h01..8'h05, no reads -> first four read back 01,02,03,04 in order, ovf=1; non-FIFO: send 01,02 -> 01 retained, ovf=1.
REQ-031 Full buffer with uart_rd_i pulsed on the cycle the next byte is accepted -> byte stored, ovf stays 0.
REQ-032 Assert sys_rst_n_i mid-DATA of 8'hFF, release, send 8'h42 -> only 8'h42 delivered, all flags 0.
